// File: rtl/ft245_device.sv
// ---------------------------------------------------------------------------
// ft245_device
//
// Device-side (chip-side) model of the FT245 synchronous FIFO interface.
// It stands in for the physical FTDI part. This allows an FT245 host-side
// master to be looped back on chip or exercised in simulation.
//
// Two byte FIFOs live inside:
//   RX : pushed from the local "pc" port, popped by the host (_rd).
//   TX : pushed by the host (_wr), popped from the local "pc" port.
//
// Ports
//   clk          : FT245 CLKOUT domain, all logic on the rising edge
//   reset        : synchronous, active-high; flushes both FIFOs
//   _rd          : host read strobe (active low), pops RX
//   _wr          : host write strobe (active low), pushes TX from data
//   _oe          : host output-enable request (active low), turns on the bus
//   _txe         : low when the host may write (TX not full)
//   _rxf         : low when the host may read (RX not empty)
//   data         : shared 8-bit bus; driven with the RX head while _oe is low
//   pc_wr_en     : push pc_wr_data into RX
//   pc_wr_data   : byte destined for the host
//   pc_full      : RX full, pc pushes refused
//   pc_rd_en     : pop the TX head
//   pc_rd_data   : TX head (show-ahead), undefined when TX is empty
//   pc_rd_valid  : TX not empty
//   err          : sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------
module ft245_device #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       _rd,
  input  logic       _wr,
  input  logic       _oe,
  output logic       _txe,
  output logic       _rxf,
  inout  wire  [7:0] data,
  input  logic       pc_wr_en,
  input  logic [7:0] pc_wr_data,
  output logic       pc_full,
  input  logic       pc_rd_en,
  output logic [7:0] pc_rd_data,
  output logic       pc_rd_valid,
  output logic       err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  // FIFO indices inside the per-FIFO arrays below
  localparam int RX = 0;
  localparam int TX = 1;

  logic [1:0] push;        // accepted push this edge, per FIFO
  logic [1:0] pop;         // accepted pop this edge, per FIFO
  logic [1:0] empty_flag;  // registered "count == 0"
  logic [1:0] full_flag;   // registered "count == DEPTH"
  logic [7:0] wdata [2];   // byte written on push
  logic [7:0] head  [2];   // registered FIFO head (show-ahead)
  logic       err_reg;

  assign wdata[RX] = pc_wr_data;
  assign wdata[TX] = data;

  // -------------------------------------------------------------------------
  // Accept logic. Every decision uses only the registered flags, so a push
  // into a full FIFO is refused even if a pop happens on the same edge.
  // The host pop does not look at _oe. The host push requires _oe high,
  // because the bus is ours while _oe is low.
  // All strobes are ignored while reset is asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    push = '0;
    pop  = '0;
    if (!reset) begin
      push[RX] = pc_wr_en & ~full_flag[RX];
      pop[RX]  = ~_rd & ~empty_flag[RX];
      push[TX] = ~_wr & ~full_flag[TX] & _oe;
      pop[TX]  = pc_rd_en & ~empty_flag[TX];
    end
  end

  // -------------------------------------------------------------------------
  // The two FIFOs share one implementation. The only difference is the reset
  // value of the full flag. TX reports "full" during reset so that _txe
  // reads high. RX reports "not full" so that pc_full reads low.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    localparam logic FULL_RST = (gi == TX);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             empty_reg;
    logic             full_reg;
    logic [7:0]       head_reg;

    always_comb begin
      wr_ptr_next = push[gi] ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
      rd_ptr_next = pop[gi]  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
      count_next  = count_reg;
      if (push[gi] && !pop[gi]) begin
        count_next = count_reg + CNT_W'(1);
      end else if (!push[gi] && pop[gi]) begin
        count_next = count_reg - CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        empty_reg  <= 1'b1;
        full_reg   <= FULL_RST;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        count_reg  <= count_next;
        empty_reg  <= (count_next == '0);
        full_reg   <= (count_next == CNT_W'(DEPTH));
      end
    end

    // Storage with a registered read of the next head address. If the
    // slot being written this edge becomes the head, the write data is
    // forwarded. This happens when the FIFO is empty, or when it holds one
    // byte and is popped on the same edge.
    always_ff @(posedge clk) begin
      if (push[gi]) begin
        mem[wr_ptr_reg] <= wdata[gi];
      end
      if (push[gi] && (wr_ptr_reg == rd_ptr_next)) begin
        head_reg <= wdata[gi];
      end else begin
        head_reg <= mem[rd_ptr_next];
      end
    end

    assign empty_flag[gi] = empty_reg;
    assign full_flag[gi]  = full_reg;
    assign head[gi]       = head_reg;
  end

  // -------------------------------------------------------------------------
  // Sticky protocol-violation flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if ((~_rd & _oe) | (~_wr & ~_oe) |
                 (pc_wr_en & full_flag[RX]) | (pc_rd_en & empty_flag[TX])) begin
      err_reg <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. The bus drive is the only combinational path from host inputs.
  // -------------------------------------------------------------------------
  assign data        = (!_oe && !reset) ? head[RX] : 8'bz;
  assign _rxf        = empty_flag[RX];
  assign _txe        = full_flag[TX];
  assign pc_full     = full_flag[RX];
  assign pc_rd_valid = ~empty_flag[TX];
  assign pc_rd_data  = head[TX];
  assign err         = err_reg;

endmodule

// File: tb/tb_ft245_device.sv
// ---------------------------------------------------------------------------
// tb_ft245_device
//
// Directed bench for ft245_device. A queue-based model tracks both FIFOs and
// the error flag from the interface rules. A compare process checks every
// DUT output against that model on each falling edge. Directed sections add
// hand-computed literal expectations for byte order and flag timing.
// Inputs change 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_ft245_device;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_n, wr_n, oe_n;
  logic       txe_n, rxf_n;
  wire  [7:0] data;
  logic       pc_wr_en;
  logic [7:0] pc_wr_data;
  logic       pc_full;
  logic       pc_rd_en;
  logic [7:0] pc_rd_data;
  logic       pc_rd_valid;
  logic       err;

  logic       tb_drv;
  logic [7:0] tb_bus;
  assign data = tb_drv ? tb_bus : 8'bz;

  int errors = 0;
  int checks = 0;

  ft245_device #(.DEPTH_LOG2(4)) dut (
    .clk         (clk),
    .reset       (reset),
    ._rd         (rd_n),
    ._wr         (wr_n),
    ._oe         (oe_n),
    ._txe        (txe_n),
    ._rxf        (rxf_n),
    .data        (data),
    .pc_wr_en    (pc_wr_en),
    .pc_wr_data  (pc_wr_data),
    .pc_full     (pc_full),
    .pc_rd_en    (pc_rd_en),
    .pc_rd_data  (pc_rd_data),
    .pc_rd_valid (pc_rd_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       m_err = 1'b0;
  logic       m_rst = 1'b1;
  logic       model_ok = 1'b0;
  int         rxn, txn;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        rx_q.delete();
        tx_q.delete();
        m_err = 1'b0;
        m_rst = 1'b1;
      end else begin
        rxn = rx_q.size();
        txn = tx_q.size();
        if ((!rd_n && oe_n) || (!wr_n && !oe_n) ||
            (pc_wr_en && rxn == DEPTH) || (pc_rd_en && txn == 0))
          m_err = 1'b1;
        // pops act on the old contents; pushes are judged on the old size
        if (!rd_n && rxn > 0) void'(rx_q.pop_front());
        if (pc_wr_en && rxn < DEPTH) rx_q.push_back(pc_wr_data);
        if (pc_rd_en && txn > 0) void'(tx_q.pop_front());
        if (!wr_n && oe_n && txn < DEPTH) tx_q.push_back(data);
        m_rst = 1'b0;
      end
      model_ok = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("txe_n",       txe_n,       m_rst ? 1 : (tx_q.size() == DEPTH));
        check("rxf_n",       rxf_n,       m_rst ? 1 : (rx_q.size() == 0));
        check("pc_full",     pc_full,     m_rst ? 0 : (rx_q.size() == DEPTH));
        check("pc_rd_valid", pc_rd_valid, m_rst ? 0 : (tx_q.size() != 0));
        check("err",         err,         m_err);
        if (!m_rst && tx_q.size() != 0) check("pc_rd_data", pc_rd_data, tx_q[0]);
        if (!oe_n && !reset && !tb_drv && rx_q.size() != 0) check("bus_head", data, rx_q[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1;
    pc_wr_en = 1'b0; pc_rd_en = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [7:0] exp3 [3];
  logic [7:0] exp_b;

  initial begin
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    reset = 1'b1; pc_wr_data = 8'h00; tb_bus = 8'h00;
    idle();

    // reset flags
    tick(); tick();
    check("rst_txe_n", txe_n, 1);
    check("rst_rxf_n", rxf_n, 1);
    check("rst_pc_full", pc_full, 0);
    check("rst_pc_rd_valid", pc_rd_valid, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();
    check("rel_txe_n", txe_n, 0);
    check("rel_rxf_n", rxf_n, 1);
    check("rel_err", err, 0);
    // bus released with _oe high: our own value reads back intact
    tb_drv = 1'b1; tb_bus = 8'hA5;
    #1 check("bus_released", data, 8'hA5);
    tb_drv = 1'b0;

    // host read order
    pc_wr_en = 1'b1; pc_wr_data = 8'h11;
    tick();
    check("rxf_after_push", rxf_n, 0);
    pc_wr_data = 8'h22; tick();
    pc_wr_data = 8'h33; tick();
    pc_wr_en = 1'b0; oe_n = 1'b0;
    tick();
    rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("host_rd_byte", data, exp3[i]);
      tick();
    end
    rd_n = 1'b1;
    check("rxf_after_3_pops", rxf_n, 1);
    oe_n = 1'b1;
    tick();

    // fill and overrun of TX
    tb_drv = 1'b1; wr_n = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      tb_bus = 8'(i);
      tick();
      if (i == 14) check("txe_before_full", txe_n, 0);
      if (i == 15) check("txe_at_full", txe_n, 1);
    end
    wr_n = 1'b1; tb_drv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("pc_valid_drain", pc_rd_valid, 1);
      check("pc_rd_byte", pc_rd_data, i);
      pc_rd_en = 1'b1;
      tick();
    end
    pc_rd_en = 1'b0;
    check("pc_valid_empty", pc_rd_valid, 0);
    check("err_after_fill", err, 0);

    // simultaneous push/pop on RX
    pc_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc_wr_data = 8'h40 + 8'(i);
      tick();
    end
    pc_wr_en = 1'b0;
    check("rx_full", pc_full, 1);
    oe_n = 1'b0;
    tick();
    // full: push refused even with the concurrent pop, so count drops to 15
    pc_wr_en = 1'b1; pc_wr_data = 8'hAA; rd_n = 1'b0;
    check("sim_full_head", data, 8'h40);
    tick();
    pc_wr_en = 1'b0; rd_n = 1'b1;
    check("sim_full_pc_full", pc_full, 0);
    check("sim_full_err", err, 1);
    // 15 bytes: push and pop both happen, 0xAA joins the tail
    pc_wr_en = 1'b1; pc_wr_data = 8'hAA; rd_n = 1'b0;
    check("sim_15_head", data, 8'h41);
    tick();
    pc_wr_en = 1'b0;
    check("sim_15_pc_full", pc_full, 0);
    for (int i = 0; i < 15; i++) begin
      exp_b = (i < 14) ? 8'h42 + 8'(i) : 8'hAA;
      check("sim_drain_byte", data, exp_b);
      tick();
    end
    rd_n = 1'b1;
    check("sim_drain_rxf", rxf_n, 1);
    do_reset();
    check("err_cleared", err, 0);

    // protocol errors
    rd_n = 1'b0; oe_n = 1'b1;
    tick();
    rd_n = 1'b1;
    check("err_rd_no_oe", err, 1);
    tick(); tick();
    check("err_sticky", err, 1);
    do_reset();
    oe_n = 1'b0;
    tick();
    wr_n = 1'b0;
    tick();
    wr_n = 1'b1; oe_n = 1'b1;
    check("wr_oe_no_push", pc_rd_valid, 0);
    check("err_wr_with_oe", err, 1);
    do_reset();

    // reset mid write burst
    tb_drv = 1'b1; wr_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tb_bus = 8'h50 + 8'(i);
      tick();
    end
    check("burst_valid", pc_rd_valid, 1);
    tb_bus = 8'h55; reset = 1'b1;
    tick();
    check("midrst_valid", pc_rd_valid, 0);
    check("midrst_txe", txe_n, 1);
    wr_n = 1'b1;
    reset = 1'b0;
    tick();
    check("post_rst_valid", pc_rd_valid, 0);
    wr_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tb_bus = 8'h60 + 8'(i);
      tick();
    end
    wr_n = 1'b1; tb_drv = 1'b0;
    check("wrap_txe_full", txe_n, 1);
    for (int i = 0; i < 16; i++) begin
      check("wrap_rd_byte", pc_rd_data, 8'h60 + 8'(i));
      pc_rd_en = 1'b1;
      tick();
    end
    pc_rd_en = 1'b0;
    check("wrap_empty", pc_rd_valid, 0);
    check("wrap_err", err, 0);

    idle();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
